// File: rtl/lbist_seq_pkg.sv
// Shared sequencer state encoding and default widths for the LBIST session sequencer.
// Imported by the RTL; the bench keeps its own behavioural view and does not rely on it.
package lbist_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SRST  = 3'd1,
        ST_APPLY = 3'd2,
        ST_DRAIN = 3'd3,
        ST_TALLY = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam int DEF_NUM_CH   = 1;
    localparam int DEF_ERR_BITS = 10;
    localparam int DEF_PAT_BITS = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lbist_seq_if.sv
// Control/status bundle between the LBIST sequencer (master) and the TPG/FIL/ORA/CUT side (slave).
// Names match the historical controller pinout so existing harnesses map one-to-one.
interface lbist_seq_if #(
    parameter int NUM_CH   = 1,
    parameter int ERR_BITS = 10
);
    logic                       START;
    logic                       ABORT;
    logic                       TPG_END;
    logic                       FIL_END;
    logic [NUM_CH-1:0]          ORA_RES;
    logic                       SYS_RESET;
    logic                       TPG_RESET;
    logic                       ORA_CLR;
    logic                       FIL_INC;
    logic                       BUSY;
    logic                       DONE;
    logic [NUM_CH*ERR_BITS-1:0] ERR_COUNT;
    logic [ERR_BITS-1:0]        FAULT_COUNT;

    modport master (
        input  START, ABORT, TPG_END, FIL_END, ORA_RES,
        output SYS_RESET, TPG_RESET, ORA_CLR, FIL_INC, BUSY, DONE, ERR_COUNT, FAULT_COUNT
    );

    modport slave (
        output START, ABORT, TPG_END, FIL_END, ORA_RES,
        input  SYS_RESET, TPG_RESET, ORA_CLR, FIL_INC, BUSY, DONE, ERR_COUNT, FAULT_COUNT
    );
endinterface

// File: rtl/lbist_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// clr has priority over inc; result visible the cycle after the request.
module lbist_seq_sat_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/lbist_seq.sv
// LBIST session sequencer: SRST, then per fault APPLY -> DRAIN -> TALLY -> NEXT until FIL_END.
// START to first APPLY cycle is RST_CYCLES+1; each fault costs its APPLY cycles plus ORA_LAT+2.
module lbist_seq
    import lbist_seq_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ERR_BITS    = DEF_ERR_BITS,
    parameter int PAT_BITS    = DEF_PAT_BITS,
    parameter int PAT_LIMIT   = 1000,
    parameter int RST_CYCLES  = 2,
    parameter int ORA_LAT     = 1,
    parameter int EARLY_ABORT = 1
) (
    input  logic       clk,
    input  logic       rst,
    lbist_seq_if.master bus
);
    localparam int WAIT_MAX = max_int(RST_CYCLES, ORA_LAT);
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0]   SRST_LAST  = WAIT_W'(RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0]   DRAIN_LAST = WAIT_W'((ORA_LAT > 0) ? (ORA_LAT - 1) : 0);
    localparam logic [PAT_BITS-1:0] PAT_LAST   = PAT_BITS'(PAT_LIMIT - 1);

    state_e              state_q, state_d;
    logic [PAT_BITS-1:0] pat_cnt_q, pat_cnt_d;
    // Shared wait timer: counts SRST cycles, then is reused for the ORA drain window.
    logic [WAIT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [NUM_CH-1:0]   det_q, det_d;
    logic                sys_reset_q, sys_reset_d;
    logic                tpg_reset_q, tpg_reset_d;
    logic                ora_clr_q, ora_clr_d;
    logic                fil_inc_q, fil_inc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [NUM_CH-1:0]   det_acc;
    logic                apply_exit;
    logic                cnt_clr;
    logic                tally;

    assign det_acc    = det_q | bus.ORA_RES;
    assign apply_exit = bus.TPG_END || (pat_cnt_q == PAT_LAST) ||
                        ((EARLY_ABORT != 0) && (&det_acc));
    assign cnt_clr    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.START && !bus.ABORT;
    assign tally      = (state_q == ST_TALLY) && !bus.ABORT;

    always_comb begin
        state_d     = state_q;
        pat_cnt_d   = pat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        det_d       = det_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.START) begin
                    state_d     = ST_SRST;
                    drain_cnt_d = '0;
                end
            end
            ST_SRST: begin
                pat_cnt_d = '0;
                det_d     = '0;
                if (drain_cnt_q == SRST_LAST) begin
                    state_d = ST_APPLY;
                end else begin
                    drain_cnt_d = drain_cnt_q + WAIT_W'(1);
                end
            end
            ST_APPLY: begin
                det_d     = det_acc;
                pat_cnt_d = pat_cnt_q + PAT_BITS'(1);
                if (apply_exit) begin
                    drain_cnt_d = '0;
                    state_d     = (ORA_LAT == 0) ? ST_TALLY : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                det_d = det_acc;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_TALLY;
                end else begin
                    drain_cnt_d = drain_cnt_q + WAIT_W'(1);
                end
            end
            ST_TALLY: begin
                state_d = bus.FIL_END ? ST_DONE : ST_NEXT;
            end
            ST_NEXT: begin
                det_d     = '0;
                pat_cnt_d = '0;
                state_d   = ST_APPLY;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.ABORT) begin
            state_d = ST_IDLE;
        end

        // Strobes decode the next state so they register in lockstep with state_q.
        sys_reset_d = (state_d == ST_SRST);
        tpg_reset_d = (state_d == ST_SRST) || (state_d == ST_NEXT);
        ora_clr_d   = (state_d == ST_SRST) || (state_d == ST_NEXT);
        fil_inc_d   = (state_d == ST_NEXT);
        busy_d      = (state_d == ST_SRST) || (state_d == ST_APPLY) || (state_d == ST_DRAIN) ||
                      (state_d == ST_TALLY) || (state_d == ST_NEXT);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pat_cnt_q   <= '0;
            drain_cnt_q <= '0;
            det_q       <= '0;
            sys_reset_q <= 1'b0;
            tpg_reset_q <= 1'b0;
            ora_clr_q   <= 1'b0;
            fil_inc_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_cnt_q   <= pat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            det_q       <= det_d;
            sys_reset_q <= sys_reset_d;
            tpg_reset_q <= tpg_reset_d;
            ora_clr_q   <= ora_clr_d;
            fil_inc_q   <= fil_inc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    logic [NUM_CH*ERR_BITS-1:0] err_count;
    logic [ERR_BITS-1:0]        fault_count;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_err
        lbist_seq_sat_cnt #(.W(ERR_BITS)) u_err_cnt (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .inc (tally && det_q[c]),
            .cnt (err_count[c*ERR_BITS +: ERR_BITS])
        );
    end

    lbist_seq_sat_cnt #(.W(ERR_BITS)) u_fault_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (tally),
        .cnt (fault_count)
    );

    assign bus.SYS_RESET   = sys_reset_q;
    assign bus.TPG_RESET   = tpg_reset_q;
    assign bus.ORA_CLR     = ora_clr_q;
    assign bus.FIL_INC     = fil_inc_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.ERR_COUNT   = err_count;
    assign bus.FAULT_COUNT = fault_count;
endmodule

// File: tb/tb_lbist_seq.sv
// Randomized session-level bench: a TPG/FIL/ORA environment model drives the sequencer and
// per-fault expectations come from the apply/drain/tally rules evaluated over pattern tables.
module tb_lbist_seq;
    localparam int NC   = 3;
    localparam int EB   = 3;
    localparam int PB   = 16;
    localparam int PL   = 8;
    localparam int RC   = 2;
    localparam int OL   = 2;
    localparam int EA   = 1;
    localparam int MAXC = (1 << EB) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lbist_seq_if #(.NUM_CH(NC), .ERR_BITS(EB)) bus ();

    lbist_seq #(
        .NUM_CH(NC), .ERR_BITS(EB), .PAT_BITS(PB), .PAT_LIMIT(PL),
        .RST_CYCLES(RC), .ORA_LAT(OL), .EARLY_ABORT(EA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [NC-1:0] ora [16][16];
    int            tpg_len [16];
    int            exp_n [16];
    logic [NC-1:0] exp_det [16];
    int            exp_err [NC];
    int            exp_fc;
    int            idx, f, nf, nfil, nsr;
    bit            prev_tpg, prev_fil;

    // One clock of the environment: TPG index restarts after TPG_RESET, FIL advances after FIL_INC.
    task automatic step();
        @(posedge clk);
        #1;
        idx = prev_tpg ? 0 : idx + 1;
        if (prev_fil) f++;
        prev_tpg = bus.TPG_RESET;
        prev_fil = bus.FIL_INC;
        bus.ORA_RES = (idx < 16 && f < 16) ? ora[f][idx] : '0;
        bus.TPG_END = (f < 16) && (idx == tpg_len[f]);
        bus.FIL_END = (f == nf - 1);
    endtask

    task automatic build(input int dens);
        for (int fi = 0; fi < 16; fi++) begin
            logic [NC-1:0] acc;
            tpg_len[fi] = $urandom_range(1, 12);
            for (int k = 0; k < 16; k++)
                for (int c = 0; c < NC; c++)
                    ora[fi][k][c] = ($urandom_range(0, 99) < dens);
            acc = '0;
            exp_n[fi] = PL;
            for (int k = 0; k < PL; k++) begin
                acc = acc | ora[fi][k];
                if (k == tpg_len[fi] || k == PL - 1 || (EA != 0 && acc == '1)) begin
                    exp_n[fi] = k + 1;
                    break;
                end
            end
            exp_det[fi] = '0;
            for (int k = 0; k < exp_n[fi] + OL; k++) exp_det[fi] = exp_det[fi] | ora[fi][k];
        end
    endtask

    task automatic tally_check();
        for (int c = 0; c < NC; c++)
            if (exp_det[f][c] && exp_err[c] < MAXC) exp_err[c]++;
        if (exp_fc < MAXC) exp_fc++;
        check("fault_len", 64'(idx), 64'(exp_n[f] + OL + 1));
        for (int c = 0; c < NC; c++)
            check("err_count", 64'(bus.ERR_COUNT[c*EB +: EB]), 64'(exp_err[c]));
        check("fault_count", 64'(bus.FAULT_COUNT), 64'(exp_fc));
    endtask

    // mode 0: run to DONE; 1: ABORT+START mid-APPLY of fault sel; 2: rst in first DRAIN cycle of fault sel.
    task automatic run_session(input int nf_i, input int dens, input int mode, input int sel);
        bit fin;
        build(dens);
        nf = nf_i; f = 0; prev_fil = 0; nfil = 0; nsr = 0; exp_fc = 0; fin = 0;
        for (int c = 0; c < NC; c++) exp_err[c] = 0;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        check("srst_entry", {bus.BUSY, bus.SYS_RESET, bus.DONE}, 3'b110);
        check("count_clr", {bus.ERR_COUNT, bus.FAULT_COUNT}, 0);
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (bus.SYS_RESET) nsr++;
            if (mode == 1 && f == sel && idx >= 1 && idx < exp_n[f] && !bus.SYS_RESET && !bus.FIL_INC) begin
                bus.ABORT = 1'b1; bus.START = 1'b1;
                step();
                bus.ABORT = 1'b0; bus.START = 1'b0;
                check("abort_status", {bus.BUSY, bus.DONE}, 2'b00);
                check("abort_strobes", {bus.SYS_RESET, bus.TPG_RESET, bus.ORA_CLR, bus.FIL_INC}, 0);
                for (int c = 0; c < NC; c++)
                    check("abort_err_kept", 64'(bus.ERR_COUNT[c*EB +: EB]), 64'(exp_err[c]));
                check("abort_fc_kept", 64'(bus.FAULT_COUNT), 64'(exp_fc));
                repeat (3) step();
                check("abort_idle_hold", {bus.BUSY, bus.SYS_RESET}, 2'b00);
                fin = 1; break;
            end
            if (mode == 2 && f == sel && idx == exp_n[f] && !bus.SYS_RESET && !bus.FIL_INC) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("rst_mid_drain", {bus.SYS_RESET, bus.TPG_RESET, bus.ORA_CLR, bus.FIL_INC,
                                        bus.BUSY, bus.DONE, bus.ERR_COUNT, bus.FAULT_COUNT}, 0);
                step();
                check("rst_idle", {bus.BUSY, bus.DONE}, 2'b00);
                fin = 1; break;
            end
            if (bus.FIL_INC) begin
                nfil++;
                tally_check();
                check("next_strobes", {bus.TPG_RESET, bus.ORA_CLR, bus.BUSY, bus.SYS_RESET}, 4'b1110);
            end
            if (bus.DONE) begin
                tally_check();
                check("done_fault_idx", 64'(f), 64'(nf - 1));
                check("fil_inc_pulses", 64'(nfil), 64'(nf - 1));
                check("srst_cycles", 64'(nsr), 64'(RC));
                check("done_busy", 64'(bus.BUSY), 0);
                repeat (2) step();
                check("done_hold", {bus.DONE, bus.BUSY, bus.FAULT_COUNT}, {1'b1, 1'b0, EB'(exp_fc)});
                fin = 1; break;
            end
            step();
        end
        if (!fin) check("session_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.TPG_END = 1'b0; bus.FIL_END = 1'b0; bus.ORA_RES = '0;
        nf = 1; f = 0; idx = 0; prev_tpg = 0; prev_fil = 0;
        for (int fi = 0; fi < 16; fi++) begin
            tpg_len[fi] = 99;
            for (int k = 0; k < 16; k++) ora[fi][k] = '0;
        end
        repeat (3) step();
        check("reset_outputs", {bus.SYS_RESET, bus.TPG_RESET, bus.ORA_CLR, bus.FIL_INC,
                                bus.BUSY, bus.DONE, bus.ERR_COUNT, bus.FAULT_COUNT}, 0);
        rst = 1'b0;
        step();
        check("idle_after_reset", {bus.BUSY, bus.DONE}, 2'b00);

        run_session(4, 8, 0, 0);
        run_session(10, 90, 0, 0);
        run_session(6, 0, 0, 0);
        run_session(5, 0, 1, 1);
        run_session(3, 20, 0, 0);
        run_session(4, 10, 2, 0);
        run_session(2, 15, 0, 0);
        for (int s = 0; s < 10; s++)
            run_session($urandom_range(1, 12), $urandom_range(0, 40), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
